// File: rtl/seg_display_mux.sv
// Multiplexed NUM_DIGITS 7-segment driver: sequential double-dabble binary-to-BCD
// conversion, shared active-low segment bus and status modes (normal/blink/dash/blank).
module seg_display_mux #(
  parameter int NUM_DIGITS  = 4,
  parameter int BIN_W       = 11,
  parameter int REFRESH_DIV = 1000,
  parameter int BLINK_DIV   = 8,
  parameter int LZ_BLANK    = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [BIN_W-1:0]      number,
  input  logic                  load,
  input  logic [1:0]            redlight,
  output logic [6:0]            seg,
  output logic [NUM_DIGITS-1:0] an,
  output logic                  busy,
  output logic                  overflow
);

  // Scratch holds every digit BIN_W bits can produce, so overflow is visible above NUM_DIGITS.
  localparam int NAT_D = (BIN_W * 3) / 10 + 1;
  localparam int SD    = (NAT_D > NUM_DIGITS) ? NAT_D : NUM_DIGITS;
  localparam int CW    = $clog2(BIN_W + 1);
  localparam int RW    = $clog2(REFRESH_DIV);
  localparam int IW    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int BW    = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_COMMIT} state_e;

  state_e                          state_q;
  logic [BIN_W-1:0]                bin_q;
  logic [4*SD-1:0]                 bcd_q, bcd_d;
  logic [CW-1:0]                   cnt_q;
  logic [NUM_DIGITS-1:0][3:0]      disp_q;
  logic                            busy_q, ovf_q, ovf_d;

  logic [RW-1:0]                   refresh_q;
  logic [IW-1:0]                   idx_q;
  logic [BW-1:0]                   round_q;
  logic                            phase_q;
  logic [6:0]                      seg_q, seg_d;
  logic [NUM_DIGITS-1:0]           an_q, an_d;
  logic                            lz_blank;

  function automatic logic [6:0] decode(input logic [3:0] nib);
    case (nib)
      4'd0: decode = 7'h40;
      4'd1: decode = 7'h79;
      4'd2: decode = 7'h24;
      4'd3: decode = 7'h30;
      4'd4: decode = 7'h19;
      4'd5: decode = 7'h12;
      4'd6: decode = 7'h02;
      4'd7: decode = 7'h78;
      4'd8: decode = 7'h00;
      4'd9: decode = 7'h10;
      default: decode = SEG_BLANK;
    endcase
  endfunction

  // NOTE: every always_comb output gets a full default first so no latch is inferred.
  always_comb begin
    bcd_d = bcd_q;
    for (int i = 0; i < SD; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_d[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
    bcd_d = {bcd_d[4*SD-2:0], bin_q[BIN_W-1]};
    ovf_d = |(bcd_q >> (4 * NUM_DIGITS));
  end

  // NOTE: sequential state uses non-blocking assignments only; the display registers
  // are reset too because a blank/zero display after reset is observable behaviour.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      bin_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      disp_q  <= '0;
      busy_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (load) begin
            bin_q   <= number;
            bcd_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          bcd_q <= bcd_d;
          bin_q <= bin_q << 1;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CW'(BIN_W - 1)) state_q <= S_COMMIT;
        end
        S_COMMIT: begin
          disp_q  <= bcd_q[4*NUM_DIGITS-1:0];
          ovf_q   <= ovf_d;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Leading-zero blanking: digit idx is blank when it and every digit above it are zero.
  always_comb begin
    lz_blank = (idx_q != '0);
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (i >= int'(idx_q) && disp_q[i] != 4'd0) lz_blank = 1'b0;
    end
    an_d = ~(NUM_DIGITS'(1) << idx_q);
    if (redlight == 2'd3)                      seg_d = SEG_BLANK;
    else if (redlight == 2'd2 || ovf_q)        seg_d = SEG_DASH;
    else if (redlight == 2'd1 && !phase_q)     seg_d = SEG_BLANK;
    else if (LZ_BLANK != 0 && lz_blank)        seg_d = SEG_BLANK;
    else                                       seg_d = decode(disp_q[idx_q]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      refresh_q <= '0;
      idx_q     <= '0;
      round_q   <= '0;
      phase_q   <= 1'b1;
      seg_q     <= SEG_BLANK;
      an_q      <= '1;
    end else begin
      seg_q <= seg_d;
      an_q  <= an_d;
      if (refresh_q == RW'(REFRESH_DIV - 1)) begin
        refresh_q <= '0;
        if (idx_q == IW'(NUM_DIGITS - 1)) begin
          idx_q <= '0;
          if (round_q == BW'(BLINK_DIV - 1)) begin
            round_q <= '0;
            phase_q <= ~phase_q;
          end else begin
            round_q <= round_q + 1'b1;
          end
        end else begin
          idx_q <= idx_q + 1'b1;
        end
      end else begin
        refresh_q <= refresh_q + 1'b1;
      end
    end
  end

  assign seg      = seg_q;
  assign an       = an_q;
  assign busy     = busy_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_seg_display_mux.sv
// Scoreboard bench for seg_display_mux: a 4-digit and a 3-digit instance, expected
// per-digit {an, seg} pairs queued from a decimal model and popped as the scan shows them.
module tb_seg_display_mux;

  localparam logic [6:0] BLANK = 7'h7F;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [10:0] num4, num3;
  logic        load4, load3;
  logic [1:0]  red4, red3;
  logic [6:0]  seg4, seg3;
  logic [3:0]  an4;
  logic [2:0]  an3;
  logic        busy4, busy3, ovf4, ovf3;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [3:0] an;
    logic [6:0] seg;
  } exp_t;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  seg_display_mux #(.NUM_DIGITS(4), .BIN_W(11), .REFRESH_DIV(4), .BLINK_DIV(2), .LZ_BLANK(1)) dut4 (
    .clk(clk), .rst_n(rst_n), .number(num4), .load(load4), .redlight(red4),
    .seg(seg4), .an(an4), .busy(busy4), .overflow(ovf4));

  seg_display_mux #(.NUM_DIGITS(3), .BIN_W(11), .REFRESH_DIV(4), .BLINK_DIV(2), .LZ_BLANK(1)) dut3 (
    .clk(clk), .rst_n(rst_n), .number(num3), .load(load3), .redlight(red3),
    .seg(seg3), .an(an3), .busy(busy3), .overflow(ovf3));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [3:0] cur_an(input int w);
    return (w == 3) ? {1'b1, an3} : an4;
  endfunction

  function automatic logic [6:0] cur_seg(input int w);
    return (w == 3) ? seg3 : seg4;
  endfunction

  function automatic logic cur_busy(input int w);
    return (w == 3) ? busy3 : busy4;
  endfunction

  function automatic logic [6:0] dec(input int d);
    case (d)
      0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
      4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
      8: return 7'h00;  default: return 7'h10;
    endcase
  endfunction

  function automatic logic [6:0] model_seg(input int v, input int d, input int nd, input int mode);
    if (mode == 3) return BLANK;
    if (mode == 2 || v >= 10 ** nd) return 7'b0111111;
    if (d > 0 && v < 10 ** d) return BLANK;
    return dec((v / (10 ** d)) % 10);
  endfunction

  task automatic expect_scan(input int w, input int v, input int mode);
    exp_t e;
    for (int d = 0; d < w; d++) begin
      e.an  = 4'hF & ~(4'b0001 << d);
      e.seg = model_seg(v, d, w, mode);
      sb_q.push_back(e);
    end
  endtask

  task automatic drain(input int w);
    exp_t e;
    int   t;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      t = 0;
      while (cur_an(w) !== e.an && t < 64) begin
        @(negedge clk);
        t++;
      end
      check("scan_an", 32'(cur_an(w)), 32'(e.an));
      check("scan_seg", 32'(cur_seg(w)), 32'(e.seg));
    end
  endtask

  task automatic do_load(input int w, input int v);
    int cnt = 0;
    @(negedge clk);
    if (w == 3) begin num3 = 11'(v); load3 = 1'b1; end
    else        begin num4 = 11'(v); load4 = 1'b1; end
    @(negedge clk);
    load3 = 1'b0;
    load4 = 1'b0;
    while (cur_busy(w) && cnt < 100) begin
      cnt++;
      @(negedge clk);
    end
    check("busy_cycles", 32'(cnt), 32'd12);
    @(negedge clk);
  endtask

  task automatic wait_round_start(input int w);
    int t = 0;
    while (cur_an(w) == 4'hE && t < 64) begin @(negedge clk); t++; end
    while (cur_an(w) != 4'hE && t < 64) begin @(negedge clk); t++; end
    check("round_start", 32'(cur_an(w)), 32'hE);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0] s[8];
    logic [3:0] prev;
    int         cnt;

    rst_n = 1'b0;
    num4 = '0; num3 = '0; load4 = 1'b0; load3 = 1'b0; red4 = 2'd0; red3 = 2'd0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_seg", 32'(seg4), 32'h7F);
    check("rst_an", 32'(an4), 32'hF);
    check("rst_busy", 32'(busy4), 32'd0);
    check("rst_ovf", 32'(ovf4), 32'd0);
    check("rst_an3", 32'(an3), 32'h7);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    expect_scan(4, 0, 0);
    drain(4);

    // 1234
    do_load(4, 1234);
    check("ovf_1234", 32'(ovf4), 32'd0);
    expect_scan(4, 1234, 0);
    drain(4);

    // 7 with leading-zero blanking, and scan period
    do_load(4, 7);
    expect_scan(4, 7, 0);
    drain(4);
    wait_round_start(4);
    cnt  = 0;
    prev = an4;
    do begin
      @(negedge clk);
      cnt++;
      if (an4 == 4'hE && prev != 4'hE) break;
      prev = an4;
    end while (cnt < 64);
    check("scan_period", 32'(cnt), 32'd16);

    // Load while busy is ignored
    @(negedge clk);
    num4 = 11'd5; load4 = 1'b1;
    @(negedge clk);
    load4 = 1'b0;
    repeat (3) @(negedge clk);
    num4 = 11'd2047; load4 = 1'b1;
    @(negedge clk);
    load4 = 1'b0;
    cnt = 0;
    while (busy4 && cnt < 100) begin @(negedge clk); cnt++; end
    check("busy_after_ignored", 32'(cnt), 32'd8);
    @(negedge clk);
    expect_scan(4, 5, 0);
    drain(4);

    // Blink: half-period of 2 rounds = 32 cycles
    red4 = 2'd1;
    wait_round_start(4);
    for (int k = 0; k < 8; k++) begin
      s[k] = seg4;
      repeat (16) @(negedge clk);
    end
    for (int k = 0; k < 8; k++)
      check("blink_value", 32'(s[k] == 7'h12 || s[k] == BLANK), 32'd1);
    for (int k = 0; k < 6; k++)
      check("blink_toggle", 32'(s[k] != s[k+2]), 32'd1);

    red4 = 2'd2;
    repeat (2) @(negedge clk);
    expect_scan(4, 5, 2);
    drain(4);
    red4 = 2'd3;
    repeat (2) @(negedge clk);
    expect_scan(4, 5, 3);
    drain(4);
    red4 = 2'd0;
    repeat (2) @(negedge clk);

    // 3-digit instance: overflow, recovery, reset mid-conversion
    do_load(3, 1500);
    check("ovf_1500", 32'(ovf3), 32'd1);
    expect_scan(3, 1500, 0);
    drain(3);
    do_load(3, 42);
    check("ovf_42", 32'(ovf3), 32'd0);
    expect_scan(3, 42, 0);
    drain(3);

    @(negedge clk);
    num3 = 11'd999; load3 = 1'b1;
    @(negedge clk);
    load3 = 1'b0;
    repeat (4) @(negedge clk);
    check("busy_mid_shift", 32'(busy3), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_busy3", 32'(busy3), 32'd0);
    check("rst_ovf3", 32'(ovf3), 32'd0);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("busy3_stays_idle", 32'(busy3), 32'd0);
    expect_scan(3, 0, 0);
    drain(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
